// File: rtl/alu_imm_pc_unit.sv
// alu_imm_pc_unit: execute-stage ALU, decode-stage immediate extension and
// fetch-stage PC+4, computed in parallel and captured in one register bank
// (1-cycle latency, synchronous active-low reset, whole-bank hold).
// Build option: define ALU_OVF_EN to produce a registered signed-overflow flag
// for add/subtract; without it the ovf port is tied to 0.
module alu_imm_pc_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [2:0]  alu_ctrl,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic        ovf,
  output logic [31:0] sign_imm,
  output logic [31:0] pc_plus4
);

  logic        sub_op;
  logic [31:0] b_opnd;
  logic [31:0] sum;
  logic [31:0] alu_res;
  logic [31:0] imm_ext;

  logic [31:0] alu_out_d,  alu_out_q;
  logic        zero_d,     zero_q;
  logic [31:0] sign_imm_d, sign_imm_q;
  logic [31:0] pc_plus4_d, pc_plus4_q;

  // ALU: one adder serves add and subtract (A + ~B + 1), plus logic ops and signed SLT
  always_comb begin
    sub_op  = (alu_ctrl == 3'b110);
    b_opnd  = sub_op ? ~src_b : src_b;
    sum     = src_a + b_opnd + {31'd0, sub_op};
    alu_res = '0;
    unique case (alu_ctrl)
      3'b000: alu_res = src_a & src_b;
      3'b001: alu_res = src_a | src_b;
      3'b010: alu_res = sum;
      3'b011: alu_res = src_a ^ src_b;
      3'b100: alu_res = src_a & ~src_b;
      3'b101: alu_res = src_a | ~src_b;
      3'b110: alu_res = sum;
      3'b111: alu_res = {31'd0, ($signed(src_a) < $signed(src_b))};
    endcase
  end

  // Immediate extension: logical immediates (andi/ori/xori) zero-extend, the rest sign-extend
  always_comb begin
    imm_ext = {{16{instr[15]}}, instr[15:0]};
    if (instr[31:26] == 6'h0C || instr[31:26] == 6'h0D || instr[31:26] == 6'h0E)
      imm_ext = {16'h0000, instr[15:0]};
  end

  // Next-state for the output bank: hold freezes every register together
  always_comb begin
    alu_out_d  = alu_out_q;
    zero_d     = zero_q;
    sign_imm_d = sign_imm_q;
    pc_plus4_d = pc_plus4_q;
    if (!hold) begin
      alu_out_d  = alu_res;
      zero_d     = (alu_res == '0);
      sign_imm_d = imm_ext;
      pc_plus4_d = pc + 32'd4;
    end
  end

  // Output register bank; reset takes priority over hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_out_q  <= '0;
      zero_q     <= 1'b0;
      sign_imm_q <= '0;
      pc_plus4_q <= '0;
    end else begin
      alu_out_q  <= alu_out_d;
      zero_q     <= zero_d;
      sign_imm_q <= sign_imm_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

`ifdef ALU_OVF_EN
  logic ovf_res;
  logic ovf_d, ovf_q;

  // Signed overflow: add overflows on like-signed operands, subtract on unlike-signed,
  // in both cases when the result sign departs from A
  always_comb begin
    ovf_res = 1'b0;
    if (alu_ctrl == 3'b010)
      ovf_res = (src_a[31] == src_b[31]) && (sum[31] != src_a[31]);
    else if (alu_ctrl == 3'b110)
      ovf_res = (src_a[31] != src_b[31]) && (sum[31] != src_a[31]);
  end

  // Overflow next-state follows the same hold rule as the rest of the bank
  always_comb begin
    ovf_d = ovf_q;
    if (!hold) ovf_d = ovf_res;
  end

  // Overflow flag register
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign alu_out  = alu_out_q;
  assign zero     = zero_q;
  assign sign_imm = sign_imm_q;
  assign pc_plus4 = pc_plus4_q;

endmodule

// File: tb/tb_alu_imm_pc_unit.sv
// Testbench for alu_imm_pc_unit: scoreboard queue of expected output banks,
// pushed when stimulus is driven and popped one edge later.
// Honours ALU_OVF_EN in its reference model.
module tb_alu_imm_pc_unit;

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic        ovf;
    logic [31:0] imm;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] alu_out;
  logic        zero;
  logic        ovf;
  logic [31:0] sign_imm;
  logic [31:0] pc_plus4;

  exp_t sb[$];
  exp_t last_exp;
  exp_t got;
  exp_t e;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  alu_imm_pc_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (hold),
    .src_a    (src_a),
    .src_b    (src_b),
    .alu_ctrl (alu_ctrl),
    .instr    (instr),
    .pc       (pc),
    .alu_out  (alu_out),
    .zero     (zero),
    .ovf      (ovf),
    .sign_imm (sign_imm),
    .pc_plus4 (pc_plus4)
  );

  always #5 clk = ~clk;

  // Independent reference: native operators, 33-bit signed sums for overflow
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] c, input logic [31:0] ins,
                                 input logic [31:0] p);
    exp_t r;
`ifdef ALU_OVF_EN
    logic [32:0] s;
`endif
    case (c)
      3'd0:    r.alu = a & b;
      3'd1:    r.alu = a | b;
      3'd2:    r.alu = a + b;
      3'd3:    r.alu = a ^ b;
      3'd4:    r.alu = a & ~b;
      3'd5:    r.alu = a | ~b;
      3'd6:    r.alu = a - b;
      default: r.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    r.zero = (r.alu == 32'd0);
    r.ovf  = 1'b0;
`ifdef ALU_OVF_EN
    if (c == 3'd2) begin
      s = {a[31], a} + {b[31], b};
      r.ovf = s[32] ^ s[31];
    end else if (c == 3'd6) begin
      s = {a[31], a} - {b[31], b};
      r.ovf = s[32] ^ s[31];
    end
`endif
    if (ins[31:26] inside {6'h0C, 6'h0D, 6'h0E}) r.imm = {16'h0000, ins[15:0]};
    else                                          r.imm = {{16{ins[15]}}, ins[15:0]};
    r.pc4 = p + 32'd4;
    return r;
  endfunction

  // Stimulus driver: applies one input set (hold low) and queues its expected bank
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                       input logic [31:0] ins, input logic [31:0] p, input exp_t ex);
    src_a = a; src_b = b; alu_ctrl = c; instr = ins; pc = p; hold = 1'b0;
    sb.push_back(ex);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      src_a = $urandom; src_b = $urandom; alu_ctrl = 3'($urandom);
      instr = $urandom; pc = $urandom; hold = (i == 0);
      @(posedge clk); #1;
      got = {alu_out, zero, ovf, sign_imm, pc_plus4};
      n_tests++;
      if (got !== exp_t'(0)) begin
        n_fail++;
        $display("FAIL reset[%0d]: got alu=%h z=%b o=%b imm=%h pc4=%h, expected all zero",
                 i, got.alu, got.zero, got.ovf, got.imm, got.pc4);
      end
    end
    last_exp = '0;
  endtask

  task automatic test_alu_sweep();
    logic [31:0] tbl [8];
    tbl = '{32'd5, 32'd7, 32'd12, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd2, 32'd0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = model(32'd7, 32'd5, 3'(i), 32'h2008_0010, 32'h0000_1000 + 32'(4 * i));
      e.alu  = tbl[i];
      e.zero = (tbl[i] == 32'd0);
      drive(32'd7, 32'd5, 3'(i), 32'h2008_0010, 32'h0000_1000 + 32'(4 * i), e);
      @(posedge clk); #1;
      got = {alu_out, zero, ovf, sign_imm, pc_plus4};
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL alu_sweep[%0d]: scoreboard empty", i); end
      else begin
        last_exp = sb.pop_front();
        if (got !== last_exp) begin
          n_fail++;
          $display("FAIL alu_sweep[%0d]: got alu=%h z=%b o=%b imm=%h pc4=%h, expected alu=%h z=%b o=%b imm=%h pc4=%h",
                   i, got.alu, got.zero, got.ovf, got.imm, got.pc4,
                   last_exp.alu, last_exp.zero, last_exp.ovf, last_exp.imm, last_exp.pc4);
        end
      end
    end
  endtask

  task automatic test_slt_zero();
    logic [31:0] av [2];
    logic [31:0] bv [2];
    logic [2:0]  cv [2];
    logic [31:0] rv [2];
    av = '{32'hFFFF_FFFF, 32'h1234_5678};
    bv = '{32'd1,         32'h1234_5678};
    cv = '{3'b111,        3'b110};
    rv = '{32'd1,         32'd0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = model(av[i], bv[i], cv[i], 32'h0000_0000, 32'h0000_2000);
      e.alu  = rv[i];
      e.zero = (i == 1);
      drive(av[i], bv[i], cv[i], 32'h0000_0000, 32'h0000_2000, e);
      @(posedge clk); #1;
      got = {alu_out, zero, ovf, sign_imm, pc_plus4};
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL slt_zero[%0d]: scoreboard empty", i); end
      else begin
        last_exp = sb.pop_front();
        if (got !== last_exp) begin
          n_fail++;
          $display("FAIL slt_zero[%0d]: got alu=%h z=%b o=%b imm=%h pc4=%h, expected alu=%h z=%b o=%b imm=%h pc4=%h",
                   i, got.alu, got.zero, got.ovf, got.imm, got.pc4,
                   last_exp.alu, last_exp.zero, last_exp.ovf, last_exp.imm, last_exp.pc4);
        end
      end
    end
  endtask

  task automatic test_imm_pc();
    logic [31:0] iv [5];
    logic [31:0] ie [5];
    logic [31:0] pv [5];
    logic [31:0] pe [5];
    iv = '{32'h2008_FFFC, 32'h3508_FFFC, 32'h8D08_0004, 32'h3108_8001, 32'h3908_8000};
    ie = '{32'hFFFF_FFFC, 32'h0000_FFFC, 32'h0000_0004, 32'h0000_8001, 32'h0000_8000};
    pv = '{32'h0040_0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h7FFF_FFFC, 32'h1234_5678};
    pe = '{32'h0040_0004, 32'h0000_0000, 32'h0000_0004, 32'h8000_0000, 32'h1234_567C};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = model(32'hF0F0_0000, 32'h0F0F_0000, 3'b001, iv[i], pv[i]);
      e.imm = ie[i];
      e.pc4 = pe[i];
      drive(32'hF0F0_0000, 32'h0F0F_0000, 3'b001, iv[i], pv[i], e);
      @(posedge clk); #1;
      got = {alu_out, zero, ovf, sign_imm, pc_plus4};
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL imm_pc[%0d]: scoreboard empty", i); end
      else begin
        last_exp = sb.pop_front();
        if (got !== last_exp) begin
          n_fail++;
          $display("FAIL imm_pc[%0d]: got alu=%h z=%b o=%b imm=%h pc4=%h, expected alu=%h z=%b o=%b imm=%h pc4=%h",
                   i, got.alu, got.zero, got.ovf, got.imm, got.pc4,
                   last_exp.alu, last_exp.zero, last_exp.ovf, last_exp.imm, last_exp.pc4);
        end
      end
    end
  endtask

  task automatic test_ovf();
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [2:0]  cv [3];
    logic        ov [3];
    av = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    bv = '{32'd1,         32'd1,         32'hFFFF_FFFF};
    cv = '{3'b010,        3'b110,        3'b010};
`ifdef ALU_OVF_EN
    ov = '{1'b1, 1'b1, 1'b0};
`else
    ov = '{1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = model(av[i], bv[i], cv[i], 32'h2008_0001, 32'h0000_3000);
      e.ovf = ov[i];
      if (i == 0) e.alu = 32'h8000_0000;
      drive(av[i], bv[i], cv[i], 32'h2008_0001, 32'h0000_3000, e);
      @(posedge clk); #1;
      got = {alu_out, zero, ovf, sign_imm, pc_plus4};
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL ovf[%0d]: scoreboard empty", i); end
      else begin
        last_exp = sb.pop_front();
        if (got !== last_exp) begin
          n_fail++;
          $display("FAIL ovf[%0d]: got alu=%h z=%b o=%b imm=%h pc4=%h, expected alu=%h z=%b o=%b imm=%h pc4=%h",
                   i, got.alu, got.zero, got.ovf, got.imm, got.pc4,
                   last_exp.alu, last_exp.zero, last_exp.ovf, last_exp.imm, last_exp.pc4);
        end
      end
    end
  endtask

  // Hold: outputs must stay at the last loaded bank while every input changes
  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hold = 1'b1;
      src_a = $urandom; src_b = $urandom; alu_ctrl = 3'($urandom);
      instr = $urandom; pc = $urandom;
      @(posedge clk); #1;
      got = {alu_out, zero, ovf, sign_imm, pc_plus4};
      n_tests++;
      if (got !== last_exp) begin
        n_fail++;
        $display("FAIL hold[%0d]: got alu=%h z=%b o=%b imm=%h pc4=%h, expected alu=%h z=%b o=%b imm=%h pc4=%h",
                 i, got.alu, got.zero, got.ovf, got.imm, got.pc4,
                 last_exp.alu, last_exp.zero, last_exp.ovf, last_exp.imm, last_exp.pc4);
      end
    end
  endtask

  // Reset beats hold, then the first edge after release with hold low loads real results
  task automatic test_reset_release();
    @(negedge clk);
    rst_n = 1'b0; hold = 1'b1;
    @(posedge clk); #1;
    got = {alu_out, zero, ovf, sign_imm, pc_plus4};
    n_tests++;
    if (got !== exp_t'(0)) begin
      n_fail++;
      $display("FAIL reset_over_hold: got alu=%h z=%b o=%b imm=%h pc4=%h, expected all zero",
               got.alu, got.zero, got.ovf, got.imm, got.pc4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    e = model(32'd9, 32'd9, 3'b011, 32'h3008_1234, 32'h0000_0100);
    drive(32'd9, 32'd9, 3'b011, 32'h3008_1234, 32'h0000_0100, e);
    @(posedge clk); #1;
    got = {alu_out, zero, ovf, sign_imm, pc_plus4};
    n_tests++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL first_after_reset: scoreboard empty"); end
    else begin
      last_exp = sb.pop_front();
      if (got !== last_exp) begin
        n_fail++;
        $display("FAIL first_after_reset: got alu=%h z=%b o=%b imm=%h pc4=%h, expected alu=%h z=%b o=%b imm=%h pc4=%h",
                 got.alu, got.zero, got.ovf, got.imm, got.pc4,
                 last_exp.alu, last_exp.zero, last_exp.ovf, last_exp.imm, last_exp.pc4);
      end
    end
  endtask

  // Back-to-back random traffic, one new input set every cycle
  task automatic test_back_to_back();
    logic [31:0] a, b, ins, p;
    logic [2:0]  c;
    logic [5:0]  opc [5];
    opc = '{6'h0C, 6'h0D, 6'h0E, 6'h08, 6'h23};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a = $urandom; b = (i % 5 == 0) ? a : $urandom;
      c = 3'($urandom); p = $urandom;
      ins = $urandom;
      ins[31:26] = opc[$urandom_range(0, 4)];
      e = model(a, b, c, ins, p);
      drive(a, b, c, ins, p, e);
      @(posedge clk); #1;
      got = {alu_out, zero, ovf, sign_imm, pc_plus4};
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL back_to_back[%0d]: scoreboard empty", i); end
      else begin
        last_exp = sb.pop_front();
        if (got !== last_exp) begin
          n_fail++;
          $display("FAIL back_to_back[%0d]: got alu=%h z=%b o=%b imm=%h pc4=%h, expected alu=%h z=%b o=%b imm=%h pc4=%h",
                   i, got.alu, got.zero, got.ovf, got.imm, got.pc4,
                   last_exp.alu, last_exp.zero, last_exp.ovf, last_exp.imm, last_exp.pc4);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    src_a = '0; src_b = '0; alu_ctrl = '0; instr = '0; pc = '0;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_alu_sweep();
    test_slt_zero();
    test_imm_pc();
    test_hold();
    test_ovf();
    test_hold();
    test_reset_release();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
